// File: rtl/full_adder_pkg.sv
// full_adder_pkg: bit-level adder equations shared by the ripple cells
package full_adder_pkg;

   function automatic logic fa_sum(input logic a, input logic b, input logic c);
      return a ^ b ^ c;
   endfunction

   // Generate (a&b) or propagate (a^b) an incoming carry.
   function automatic logic fa_carry(input logic a, input logic b, input logic c);
      return (a & b) | (c & (a ^ b));
   endfunction

endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: combinational 1-bit full adder
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module full_adder_cell
   import full_adder_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = fa_sum(a, b, ci);
   assign co = fa_carry(a, b, ci);

endmodule

// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder, optional one-stage output register
//   clk, rst_n : clock, asynchronous active-low reset (unused when REGISTERED=0)
//   in_valid   : a, b, c_in valid this cycle
//   a, b       : unsigned operands
//   c_in       : carry into bit 0
//   out_valid  : s / c_out hold a fresh result
//   s          : sum modulo 2^WIDTH
//   c_out      : carry out of bit WIDTH-1
module full_adder #(
   parameter int WIDTH      = 1,
   parameter bit REGISTERED = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   output logic [WIDTH-1:0] s,
   output logic             c_out
);

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] sum;

   assign c[0] = c_in;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_adder_cell u_cell (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (sum[i]),
         .co (c[i+1])
      );
   end

   if (REGISTERED) begin : g_reg
      // Load only on valid so that garbage on idle operands never reaches s/c_out.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            c_out     <= 1'b0;
         end else begin
            out_valid <= in_valid;
            if (in_valid) begin
               s     <= sum;
               c_out <= c[WIDTH];
            end
         end
      end
   end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign out_valid      = in_valid;
      assign s              = sum;
      assign c_out          = c[WIDTH];
   end

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       ci;
      logic       v;
      logic [4:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       v1 = 0, a1 = 0, b1 = 0, c1 = 0;
   logic       ov1, s1, co1;
   logic       v4 = 0, c4 = 0;
   logic [3:0] a4 = 0, b4 = 0, s4;
   logic       ov4, co4;
   logic       v0 = 0, a0 = 0, b0 = 0, c0 = 0;
   logic       ov0, s0, co0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   full_adder #(.WIDTH(1), .REGISTERED(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .c_in(c1),
      .out_valid(ov1), .s(s1), .c_out(co1));

   full_adder #(.WIDTH(4), .REGISTERED(1)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .c_in(c4),
      .out_valid(ov4), .s(s4), .c_out(co4));

   full_adder #(.WIDTH(1), .REGISTERED(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(v0), .a(a0), .b(b0), .c_in(c0),
      .out_valid(ov0), .s(s0), .c_out(co0));

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   vec_t tt[8];
   vec_t wr[3];
   logic [4:0] model;
   logic       model_v;

   initial begin
      tt[0] = '{4'd0, 4'd0, 1'b0, 1'b1, 5'b00};
      tt[1] = '{4'd0, 4'd0, 1'b1, 1'b1, 5'b01};
      tt[2] = '{4'd0, 4'd1, 1'b0, 1'b1, 5'b01};
      tt[3] = '{4'd0, 4'd1, 1'b1, 1'b1, 5'b10};
      tt[4] = '{4'd1, 4'd0, 1'b0, 1'b1, 5'b01};
      tt[5] = '{4'd1, 4'd0, 1'b1, 1'b1, 5'b10};
      tt[6] = '{4'd1, 4'd1, 1'b0, 1'b1, 5'b10};
      tt[7] = '{4'd1, 4'd1, 1'b1, 1'b1, 5'b11};
      wr[0] = '{4'd15, 4'd0,  1'b1, 1'b1, 5'd16};
      wr[1] = '{4'd7,  4'd8,  1'b0, 1'b1, 5'd15};
      wr[2] = '{4'd15, 4'd15, 1'b1, 1'b1, 5'd31};

      // reset state
      repeat (2) step();
      chk("reset1", {5'b0, ov1, co1, s1}, 8'h00);
      chk("reset4", {2'b0, ov4, co4, s4}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("post_release_ov", {6'b0, ov1, ov4}, 8'h00);

      // exhaustive 1-bit truth table, back to back
      for (int i = 0; i < 8; i++) begin
         v1 = 1; a1 = tt[i].a[0]; b1 = tt[i].b[0]; c1 = tt[i].ci;
         step();
         chk($sformatf("tt%0d", i), {6'b0, co1, s1}, {6'b0, tt[i].exp[1:0]});
         chk($sformatf("tt%0d_ov", i), {7'b0, ov1}, 8'h01);
      end

      // hold with idle inputs changing
      v1 = 1; a1 = 1; b1 = 1; c1 = 0;
      step();
      chk("hold_load", {6'b0, co1, s1}, 8'h02);
      v1 = 0; a1 = 0; b1 = 0; c1 = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("hold%0d", i), {5'b0, ov1, co1, s1}, 8'h02);
      end

      // asynchronous reset mid-cycle
      v1 = 1; a1 = 1; b1 = 1; c1 = 1;
      step();
      chk("ar_load", {5'b0, ov1, co1, s1}, 8'h07);
      #2 rst_n = 1'b0;
      #1 chk("ar_immediate", {5'b0, ov1, co1, s1}, 8'h00);
      v1 = 0;
      #1 rst_n = 1'b1;
      step();
      chk("ar_after_release", {5'b0, ov1, co1, s1}, 8'h00);
      v1 = 1; a1 = 0; b1 = 1; c1 = 0;
      step();
      chk("ar_reload", {5'b0, ov1, co1, s1}, 8'h05);
      v1 = 0;

      // 4-bit wrap-around
      for (int i = 0; i < 3; i++) begin
         v4 = 1; a4 = wr[i].a; b4 = wr[i].b; c4 = wr[i].ci;
         step();
         chk($sformatf("wrap%0d", i), {3'b0, co4, s4}, {3'b0, wr[i].exp});
      end
      model = 5'd31;

      // 4-bit random against arithmetic reference
      for (int i = 0; i < 1000; i++) begin
         v4 = ($urandom_range(0, 1) == 1);
         a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
         if (v4) model = 5'(a4) + 5'(b4) + 5'(c4);
         model_v = v4;
         step();
         chk($sformatf("rnd%0d", i), {2'b0, ov4, co4, s4}, {2'b0, model_v, model});
      end
      v4 = 0;

      // combinational variant, same-timestep response
      for (int i = 0; i < 8; i++) begin
         v0 = i[0] ^ i[2]; a0 = tt[i].a[0]; b0 = tt[i].b[0]; c0 = tt[i].ci;
         #10;
         chk($sformatf("comb%0d", i), {5'b0, ov0, co0, s0}, {5'b0, v0, tt[i].exp[1:0]});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
